// File: rtl/fft_stage_controller.sv
// Address/strobe sequencer for an in-place radix-2 DIT FFT over a dual-port sample RAM.
// Issues one butterfly read per cycle and replays the addresses RD_LAT cycles later as write-back.
module fft_stage_controller #(
  parameter int LOG2N  = 3,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int J_W = LOG2N - 1;
  localparam int C_W = 3;
  localparam logic [J_W-1:0]   J_LAST   = {J_W{1'b1}};
  localparam logic [C_W-1:0]   CNT_LAST = C_W'(RD_LAT - 1);
  localparam logic [LOG2N-1:0] S_LAST   = LOG2N'(LOG2N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [LOG2N-1:0] s_r, s_s;
  logic [J_W-1:0]   j_r, j_s;
  logic [C_W-1:0]   cnt_r, cnt_s;

  logic [RD_LAT-1:0] pipe_en_r;
  logic [LOG2N-1:0]  pipe_a_r [RD_LAT];
  logic [LOG2N-1:0]  pipe_b_r [RD_LAT];

  // Mask of the bits of j below the butterfly span (j mod 2^s).
  function automatic logic [LOG2N-1:0] low_mask_f(input logic [LOG2N-1:0] s);
    return (LOG2N'(1) << s) - LOG2N'(1);
  endfunction

  // A address: group bits move up one position to open a hole at bit s, position bits stay.
  function automatic logic [LOG2N-1:0] addr_a_f(input logic [LOG2N-1:0] s, input logic [J_W-1:0] j);
    logic [LOG2N-1:0] jw;
    jw = {1'b0, j};
    return ((jw & ~low_mask_f(s)) << 1'b1) | (jw & low_mask_f(s));
  endfunction

  // B address sits exactly half a span above A; bit s of A is always clear.
  function automatic logic [LOG2N-1:0] addr_b_f(input logic [LOG2N-1:0] s, input logic [J_W-1:0] j);
    return addr_a_f(s, j) | (LOG2N'(1) << s);
  endfunction

  function automatic logic [J_W-1:0] tw_f(input logic [LOG2N-1:0] s, input logic [J_W-1:0] j);
    logic [LOG2N-1:0] full;
    full = ({1'b0, j} & low_mask_f(s)) << (S_LAST - s);
    return full[J_W-1:0];
  endfunction

  // FSM and loop-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      s_r     <= '0;
      j_r     <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      s_r     <= s_s;
      j_r     <= j_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and loop-counter logic.
  always_comb begin
    state_s = state_r;
    s_s     = s_r;
    j_s     = j_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          s_s     = '0;
          j_s     = '0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (j_r == J_LAST) begin
          state_s = DRAIN;
          cnt_s   = '0;
        end else begin
          j_s = j_r + J_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_r == CNT_LAST) begin
          if (s_r < S_LAST) begin
            state_s = RUN;
            s_s     = s_r + LOG2N'(1);
            j_s     = '0;
          end else begin
            state_s = DONE;
          end
        end else begin
          cnt_s = cnt_r + C_W'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      busy  <= (state_s == RUN) || (state_s == DRAIN);
      done  <= (state_s == DONE);
      stage <= s_s;
      rd_en <= (state_s == RUN);
      if (state_s == RUN) begin
        rd_addr_a <= addr_a_f(s_s, j_s);
        rd_addr_b <= addr_b_f(s_s, j_s);
        tw_addr   <= tw_f(s_s, j_s);
      end else begin
        rd_addr_a <= rd_addr_a;
        rd_addr_b <= rd_addr_b;
        tw_addr   <= tw_addr;
      end
    end
  end

  // Write-back delay line; reset drops any strobes still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_en_r <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_a_r[i] <= '0;
        pipe_b_r[i] <= '0;
      end
    end else begin
      pipe_en_r[0] <= rd_en;
      pipe_a_r[0]  <= rd_addr_a;
      pipe_b_r[0]  <= rd_addr_b;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_en_r[i] <= pipe_en_r[i-1];
        pipe_a_r[i]  <= pipe_a_r[i-1];
        pipe_b_r[i]  <= pipe_b_r[i-1];
      end
    end
  end

  assign wr_en     = pipe_en_r[RD_LAT-1];
  assign wr_addr_a = pipe_a_r[RD_LAT-1];
  assign wr_addr_b = pipe_b_r[RD_LAT-1];

endmodule
